combat_scheduler: RTL

COMBAT_SCHEDULER -- requirements
Module: combat_scheduler

---
 rtl/combat_scheduler_pkg.sv | 36 +++
 rtl/combat_damage_calc.sv | 39 +++
 rtl/combat_scheduler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/combat_scheduler_pkg.sv
// Shared definitions for the turn-based pet combat scheduler: action codes,
// FSM state encoding, stat-word field positions and heal constants.
package combat_scheduler_pkg;

  typedef enum logic [1:0] {
    ACT_ATTACK = 2'd0,
    ACT_DEFEND = 2'd1,
    ACT_HEAL   = 2'd2,
    ACT_PASS   = 2'd3
  } act_e;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_ACT,
    RD_SRC,
    RD_TGT,
    CALC,
    WRITE,
    END_TURN,
    WAIT_SWITCH,
    CHK_SWITCH,
    OVER
  } state_e;

  // Pet word layout: {ATK[8:6], DEF[5:3], HP[2:0]}
  localparam int HP_LSB  = 0;
  localparam int HP_MSB  = 2;
  localparam int DEF_LSB = 3;
  localparam int DEF_MSB = 5;
  localparam int ATK_LSB = 6;
  localparam int ATK_MSB = 8;

  localparam logic [3:0] HEAL_AMT = 4'd2;
  localparam logic [3:0] HP_MAX   = 4'd7;

endpackage

// File: rtl/combat_damage_calc.sv
// Pure combinational HP update for one attack or heal; arithmetic is done
// in 4 bits so subtraction clamps at 0 and heal saturates at HP_MAX.
module combat_damage_calc
  import combat_scheduler_pkg::*;
(
  input  logic [8:0] src,
  input  logic [8:0] tgt,
  input  logic       blk,
  input  logic [1:0] code,
  output logic [2:0] new_hp
);

  logic [3:0] atk;
  logic [3:0] def;
  logic [3:0] hp;
  logic [3:0] dmg;
  logic [3:0] sum;
  logic       unused_bits;

  assign unused_bits = ^{src[DEF_MSB:HP_LSB], tgt[ATK_MSB:ATK_LSB]};

  always_comb begin
    atk = {1'b0, src[ATK_MSB:ATK_LSB]};
    def = {1'b0, tgt[DEF_MSB:DEF_LSB]};
    hp  = {1'b0, tgt[HP_MSB:HP_LSB]};
    dmg = atk;
    if (blk) begin
      dmg = (atk > def) ? (atk - def) : 4'd0;
    end
    sum    = hp + HEAL_AMT;
    new_hp = hp[2:0];
    case (act_e'(code))
      ACT_ATTACK: new_hp = (hp > dmg) ? 3'(hp - dmg) : 3'd0;
      ACT_HEAL:   new_hp = (sum > HP_MAX) ? HP_MAX[2:0] : sum[2:0];
      default:    new_hp = hp[2:0];
    endcase
  end

endmodule

// File: rtl/combat_scheduler.sv
// Two-player pet combat turn scheduler: accepts one action per turn, runs a
// read-read-write sequence against the external stat RAM, handles KO/switch.
module combat_scheduler
  import combat_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] p1_sel,
  input  logic [1:0] p2_sel,
  input  logic       sel_valid,
  input  logic       act_valid,
  input  logic       act_player,
  input  logic [1:0] act_code,
  output logic       act_ready,
  output logic [2:0] stat_rd_addr,
  input  logic [8:0] stat_rd_data,
  output logic       stat_wr_en,
  output logic [2:0] stat_wr_addr,
  output logic [8:0] stat_wr_data,
  output logic       turn,
  output logic       busy,
  output logic       ko,
  output logic       game_over,
  output logic       winner
);

  state_e     state, state_next;
  act_e       act_q;
  logic [1:0] pet1, pet2, sw_sel;
  logic [3:0] alive1, alive2;
  logic       blk1, blk2;
  logic [8:0] src_word, tgt_word;
  logic [2:0] new_hp;
  logic       accept, start_ok, tgt_player, tgt_blk, ko_player, hp_zero;
  logic [1:0] mover_pet, tgt_pet;
  logic [3:0] tgt_alive_left, ko_alive;

  // Handshake: an action transfers on a cycle where act_valid && act_ready
  // and act_player matches turn; any other act_valid is simply dropped.
  assign accept         = (state == WAIT_ACT) && act_valid && (act_player == turn);
  assign start_ok       = start && ((state == IDLE) || (state == OVER));
  assign tgt_player     = (act_q == ACT_HEAL) ? turn : ~turn;
  assign mover_pet      = turn ? pet2 : pet1;
  assign tgt_pet        = tgt_player ? pet2 : pet1;
  assign tgt_blk        = tgt_player ? blk2 : blk1;
  assign tgt_alive_left = (tgt_player ? alive2 : alive1) & ~(4'b0001 << tgt_pet);
  assign ko_player      = ~turn;
  assign ko_alive       = ko_player ? alive2 : alive1;
  assign hp_zero        = (new_hp == 3'd0);

  combat_damage_calc u_calc (
    .src    (src_word),
    .tgt    (tgt_word),
    .blk    (tgt_blk),
    .code   (act_q),
    .new_hp (new_hp)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    act_ready    = 1'b0;
    busy         = 1'b1;
    stat_rd_addr = 3'd0;
    stat_wr_en   = 1'b0;
    stat_wr_addr = 3'd0;
    stat_wr_data = 9'd0;
    ko           = 1'b0;
    game_over    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = WAIT_ACT;
      end
      WAIT_ACT: begin
        busy      = 1'b0;
        act_ready = 1'b1;
        if (accept) begin
          if ((act_code == ACT_ATTACK) || (act_code == ACT_HEAL)) state_next = RD_SRC;
          else                                                     state_next = END_TURN;
        end
      end
      RD_SRC: begin
        stat_rd_addr = {turn, mover_pet};
        state_next   = RD_TGT;
      end
      RD_TGT: begin
        stat_rd_addr = {tgt_player, tgt_pet};
        state_next   = CALC;
      end
      CALC: state_next = WRITE;
      WRITE: begin
        stat_wr_en   = 1'b1;
        stat_wr_addr = {tgt_player, tgt_pet};
        stat_wr_data = {tgt_word[ATK_MSB:DEF_LSB], new_hp};
        if (hp_zero) begin
          ko         = 1'b1;
          state_next = (tgt_alive_left == 4'd0) ? OVER : WAIT_SWITCH;
        end else begin
          state_next = END_TURN;
        end
      end
      END_TURN: state_next = WAIT_ACT;
      WAIT_SWITCH: begin
        if (sel_valid) state_next = CHK_SWITCH;
      end
      CHK_SWITCH: state_next = ko_alive[sw_sel] ? END_TURN : WAIT_SWITCH;
      OVER: begin
        game_over = 1'b1;
        if (start) state_next = WAIT_ACT;
      end
      default: state_next = IDLE;
    endcase
    // Reset wins over a write already presented this cycle
    if (reset) begin
      stat_wr_en = 1'b0;
      ko         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      turn     <= 1'b0;
      winner   <= 1'b0;
      pet1     <= 2'd0;
      pet2     <= 2'd0;
      sw_sel   <= 2'd0;
      alive1   <= 4'd0;
      alive2   <= 4'd0;
      blk1     <= 1'b0;
      blk2     <= 1'b0;
      act_q    <= ACT_ATTACK;
      src_word <= 9'd0;
      tgt_word <= 9'd0;
    end else begin
      if (start_ok) begin
        turn   <= 1'b0;
        winner <= 1'b0;
        alive1 <= 4'b1111;
        alive2 <= 4'b1111;
        blk1   <= 1'b0;
        blk2   <= 1'b0;
        pet1   <= p1_sel;
        pet2   <= p2_sel;
      end
      if (accept) begin
        act_q <= act_e'(act_code);
        if (turn) blk2 <= (act_code == ACT_DEFEND);
        else      blk1 <= (act_code == ACT_DEFEND);
      end
      if (state == RD_TGT) src_word <= stat_rd_data;
      if (state == CALC)   tgt_word <= stat_rd_data;
      if ((state == WRITE) && hp_zero) begin
        if (tgt_player) alive2 <= tgt_alive_left;
        else            alive1 <= tgt_alive_left;
        if (tgt_alive_left == 4'd0) winner <= turn;
      end
      if (state == END_TURN) turn <= ~turn;
      if ((state == WAIT_SWITCH) && sel_valid) sw_sel <= ko_player ? p2_sel : p1_sel;
      if ((state == CHK_SWITCH) && ko_alive[sw_sel]) begin
        if (ko_player) pet2 <= sw_sel;
        else           pet1 <= sw_sel;
      end
    end
  end

endmodule
